// File: rtl/ham_pkg.sv
// Shared Hamming(17,12) definitions used by the encoder, the arbiter top and any future decoder.
package ham_pkg;

    localparam int DATA_W = 12;
    localparam int CODE_W = 17;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CODE_W-1:0] code_t;

endpackage : ham_pkg

// File: rtl/hamEncode125.sv
// Combinational Hamming encoder: 12 data bits, 5 parity bits, 17-bit codeword.
// Codeword position p (1-based) is OUT[p-1]. Parity sits at positions 1,2,4,8,16,
// data bits d0..d11 fill positions 3,5,6,7,9..15,17 in ascending order, and each
// parity bit is the XOR of every data position whose index shares that bit.
module hamEncode125
    import ham_pkg::*;
(
    input  data_t IN,
    output code_t OUT
);

    logic p1;
    logic p2;
    logic p4;
    logic p8;
    logic p16;

    assign p1  = IN[0] ^ IN[1] ^ IN[3] ^ IN[4] ^ IN[6] ^ IN[8] ^ IN[10] ^ IN[11];
    assign p2  = IN[0] ^ IN[2] ^ IN[3] ^ IN[5] ^ IN[6] ^ IN[9] ^ IN[10];
    assign p4  = IN[1] ^ IN[2] ^ IN[3] ^ IN[7] ^ IN[8] ^ IN[9] ^ IN[10];
    assign p8  = ^IN[10:4];
    assign p16 = IN[11];

    assign OUT = {IN[11], p16, IN[10:4], p8, IN[3:1], p4, IN[0], p2, p1};

endmodule : hamEncode125

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Requests at or above ptr are placed in the
// low half of a double-width vector and all requests in the high half, so the
// lowest set bit is the first requester at or after ptr, wrapping naturally.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic [NREQ-1:0]   hi_mask;
    logic [2*NREQ-1:0] dbl;
    logic              found;

    // Thermometer mask selecting requesters at or above the pointer.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
    end

    assign dbl = {req, req & hi_mask};

    // Lowest set bit of the double-width vector picks the winner; folded back modulo NREQ.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int i = 0; i < 2 * NREQ; i++) begin
            if (dbl[i] && !found) begin
                found   = 1'b1;
                gnt_idx = IDW'(i % NREQ);
            end
        end
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule : rr_arbiter

// File: rtl/ham_encode_arbiter.sv
// Shares one Hamming encoder among NREQ requesters: round-robin pick, encode,
// and park the codeword with its source ID in a one-entry output register.
module ham_encode_arbiter
    import ham_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NREQ-1:0]        in_valid,
    input  logic [NREQ*DATA_W-1:0] in_data,
    output logic [NREQ-1:0]        in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output code_t                  out_code,
    output logic [IDW-1:0]         out_id,
    output logic [15:0]            word_cnt
);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic            adv;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            xfer;
    data_t           sel_data;
    code_t           enc_code;

    // The register can take a new word when it is empty or being drained this cycle.
    // Gating with resetn keeps every in_ready low while reset is held.
    assign adv = (!out_valid || out_ready) && resetn;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (in_valid),
        .en      (adv),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign in_ready = gnt;
    assign xfer     = |gnt;
    assign sel_data = in_data[int'(gnt_idx)*DATA_W +: DATA_W];
    assign ptr_next = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;

    hamEncode125 u_enc (
        .IN  (sel_data),
        .OUT (enc_code)
    );

    // Output register and round-robin pointer: load on transfer, clear valid on a bare drain.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the word register is reset too, because out_code is visible and defined as 0 in reset.
        if (!resetn) begin
            out_valid <= 1'b0;
            out_code  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid <= 1'b1;
            out_code  <= enc_code;
            out_id    <= gnt_idx;
            ptr       <= ptr_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Delivered-codeword counter; wraps at 16 bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_cnt <= '0;
        end else if (out_valid && out_ready) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

endmodule : ham_encode_arbiter
